mem_dp: RTL and testbench
=========================

MEM_DP -- requirements
Module: mem_dp

Interface
REQ-001 The block SHALL expose these parameters, one per line: name, default, meaning.
- DATA_WIDTH  6  word width in bits
- ADDR_WIDTH  8  address width in bits
- RAM_DEPTH  1<<ADDR_WIDTH  number of words
- RD_LATENCY  1  read latency in cycles; legal values 1 or 2
- WRITE_FIRST  1  collision mode; 1 = new data, 0 = old data
REQ-002 The block SHALL expose these ports, one per line: name  direction  width  meaning.
- clk  input  1  single clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high reset
- wr_en  input  1  write request
- wr_addr  input  ADDR_WIDTH  write address
- wr_data  input  DATA_WIDTH  write data
- rd_en  input  1  read request
- rd_addr  input  ADDR_WIDTH  read address
- rd_data  output  DATA_WIDTH  read data, registered
- rd_valid  output  1  rd_data carries a fresh read result this cycle
- init_busy  output  1  clear sequence in progress; requests are ignored
REQ-003 The block SHALL have one clock and one reset: reset is asynchronous and active-high, clk is the only clock.

Function
REQ-004 The controller SHALL have two states, INIT and RUN; reset forces INIT with the clear counter at 0.
REQ-005 In INIT, the block SHALL write 0 to location clear_cnt each cycle and increment clear_cnt; after the write to RAM_DEPTH-1 it SHALL enter RUN.
REQ-006 init_busy SHALL be 1 in INIT and 0 in RUN, so it stays high for exactly RAM_DEPTH cycles after reset deasserts.
REQ-007 In INIT, wr_en and rd_en SHALL be ignored: no user write, and no rd_valid pulse results.
REQ-008 In RUN, wr_en=1 SHALL write wr_data to mem[wr_addr] at the clock edge.
REQ-009 In RUN, rd_en=1 SHALL sample mem[rd_addr]; with RD_LATENCY=1, rd_data/rd_valid appear after the next edge; with RD_LATENCY=2, one cycle later through an extra pipeline register.
REQ-010 Reads SHALL be fully pipelined: back-to-back rd_en SHALL give back-to-back rd_valid in request order with no bubbles.
REQ-011 rd_valid SHALL be a one-cycle pulse per accepted read.
REQ-012 rd_data SHALL hold its last value when no read completes; it is never forced to zero outside reset.
REQ-013 If wr_en and rd_en are both 1 with wr_addr==rd_addr in RUN:
- WRITE_FIRST=1: the read returns wr_data.
- WRITE_FIRST=0: the read returns the previous contents.
- Either way, the write completes.
REQ-014 Simultaneous reads and writes to different addresses SHALL both complete with no interaction.
REQ-015 A read issued on the last INIT cycle SHALL be dropped; the first accepted read is on the first RUN cycle.
REQ-016 Any RD_LATENCY value other than 1 or 2 SHALL be rejected at elaboration.

Reset
REQ-017 While reset=1, the block SHALL hold rd_data=0, rd_valid=0, init_busy=1, state=INIT, clear_cnt=0, and clear all read pipeline stages.
REQ-018 Reset asserted mid-operation, in INIT or RUN, SHALL take effect immediately without waiting for clk and SHALL discard in-flight reads.
REQ-019 Reset SHALL NOT touch the memory array directly; contents are zeroed only by the INIT sweep after reset deasserts.

Verification
REQ-020 Post-reset clear:
- Stimulus: write 0x2A to address 0x10 in RUN, apply reset, wait for init_busy to fall, then read 0x10.
- Required: init_busy high for 256 cycles; the read returns 0x00.
REQ-021 Basic latency:
- Stimulus: write 0x15 to address 0x03, then rd_en at 0x03.
- Required: rd_valid=1 and rd_data=0x15 exactly 1 cycle later with RD_LATENCY=1, and exactly 2 cycles later with RD_LATENCY=2.
REQ-022 Collision:
- Stimulus: mem[0x40]=0x01; same cycle wr 0x3F to 0x40 and rd 0x40.
- Required: rd_data=0x3F with WRITE_FIRST=1, or 0x01 with WRITE_FIRST=0; a following read of 0x40 returns 0x3F in both modes.
REQ-023 Streaming:
- Stimulus: fill addresses 0..7 with values 0..7, then rd_en for 8 consecutive cycles over addresses 0..7.
- Required: 8 consecutive rd_valid pulses with data 0..7 in order.
REQ-024 Requests during INIT:
- Stimulus: rd_en and wr_en (0x3F to 0x00) during INIT.
- Required: no rd_valid; after INIT, address 0x00 reads 0x00.
REQ-025 Mid-read reset:
- Stimulus: assert reset between rd_en and the expected rd_valid.
- Required: rd_valid never pulses; rd_data=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/mem_dp.sv
// Simple dual-port RAM with a post-reset zeroing sweep, 1- or 2-cycle registered
// read latency and a selectable same-address read/write collision policy.
module mem_dp #(
  parameter int DATA_WIDTH  = 6,
  parameter int ADDR_WIDTH  = 8,
  parameter int RAM_DEPTH   = 1 << ADDR_WIDTH,
  parameter int RD_LATENCY  = 1,
  parameter bit WRITE_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  init_busy
);

  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_rd_latency
    $error("mem_dp: RD_LATENCY must be 1 or 2");
  end

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_clear_cnt;
  logic [ADDR_WIDTH-1:0] w_clear_cnt_next;
  logic                  w_clear_last;

  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_data;
  logic                  w_rd_accept;
  logic                  w_collision;
  logic [DATA_WIDTH-1:0] w_rd_word;

  logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

  logic                  r_s1_valid;
  logic [DATA_WIDTH-1:0] r_s1_data;

  assign w_clear_last = (r_clear_cnt == ADDR_WIDTH'(RAM_DEPTH - 1));
  assign init_busy    = (r_state == ST_INIT);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_INIT;
      r_clear_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_clear_cnt <= w_clear_cnt_next;
    end
  end

  // The INIT sweep owns the write port; user requests only reach the array in RUN.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_next     = r_state;
    w_clear_cnt_next = r_clear_cnt;
    w_mem_we         = 1'b0;
    w_mem_addr       = wr_addr;
    w_mem_data       = wr_data;
    w_rd_accept      = 1'b0;
    unique case (r_state)
      ST_INIT: begin
        w_mem_we         = 1'b1;
        w_mem_addr       = r_clear_cnt;
        w_mem_data       = '0;
        w_clear_cnt_next = r_clear_cnt + ADDR_WIDTH'(1);
        if (w_clear_last) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_mem_we    = wr_en;
        w_rd_accept = rd_en;
      end
      default: w_state_next = ST_INIT;
    endcase
  end

  // NOTE: the array has no reset so it maps onto block RAM; the INIT sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  // Only user writes can collide; the array read already yields the old word.
  assign w_collision = wr_en && (wr_addr == rd_addr);
  assign w_rd_word   = (WRITE_FIRST && w_collision) ? wr_data : r_mem[rd_addr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= w_rd_accept;
      if (w_rd_accept) begin
        r_s1_data <= w_rd_word;
      end
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic                  r_s2_valid;
    logic [DATA_WIDTH-1:0] r_s2_data;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_s2_valid <= 1'b0;
        r_s2_data  <= '0;
      end else begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_data <= r_s1_data;
        end
      end
    end

    assign rd_valid = r_s2_valid;
    assign rd_data  = r_s2_data;
  end else begin : g_lat1
    assign rd_valid = r_s1_valid;
    assign rd_data  = r_s1_data;
  end

endmodule

// File: tb/tb_mem_dp.sv
// Bench for mem_dp: one instance with 1-cycle write-first reads, one with 2-cycle
// read-first reads, sharing stimulus; read results are checked through per-instance queues.
module tb_mem_dp;

  localparam int DW    = 6;
  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk     = 1'b0;
  logic          reset   = 1'b0;
  logic          wr_en   = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en   = 1'b0;
  logic [AW-1:0] rd_addr = '0;

  logic [DW-1:0] rd_data1, rd_data2;
  logic          rd_valid1, rd_valid2;
  logic          busy1, busy2;

  always #5 clk = ~clk;

  mem_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1), .WRITE_FIRST(1'b1)) dut1 (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .init_busy(busy1)
  );

  mem_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(2), .WRITE_FIRST(1'b0)) dut2 (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data2), .rd_valid(rd_valid2), .init_busy(busy2)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  typedef struct {
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] exp1;
    logic [DW-1:0] exp2;
  } vec_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  vec_t tbl[12];
  vec_t v;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int m_left   = DEPTH;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference clear-sweep timing: busy for DEPTH edges after reset releases.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left <= DEPTH;
    end else begin
      cyc <= cyc + 1;
      if (m_left > 0) m_left <= m_left - 1;
    end
  end

  always @(negedge clk) begin
    check("init_busy lat1", 32'(busy1), 32'(reset || (m_left > 0)));
    check("init_busy lat2", 32'(busy2), 32'(reset || (m_left > 0)));
    if (reset) begin
      check("reset rd_valid lat1", 32'(rd_valid1), 32'd0);
      check("reset rd_data lat1", 32'(rd_data1), 32'd0);
      check("reset rd_valid lat2", 32'(rd_valid2), 32'd0);
      check("reset rd_data lat2", 32'(rd_data2), 32'd0);
    end else begin
      if (rd_valid1) begin
        if (q1.size() == 0) begin
          check("unexpected rd_valid lat1", 32'(rd_valid1), 32'd0);
        end else begin
          e1 = q1.pop_front();
          check("read timing lat1", 32'(cyc), 32'(e1.due));
          check("read data lat1", 32'(rd_data1), 32'(e1.data));
        end
      end else if (q1.size() > 0 && q1[0].due <= cyc) begin
        check("missing rd_valid lat1", 32'(rd_valid1), 32'd1);
        void'(q1.pop_front());
      end
      if (rd_valid2) begin
        if (q2.size() == 0) begin
          check("unexpected rd_valid lat2", 32'(rd_valid2), 32'd0);
        end else begin
          e2 = q2.pop_front();
          check("read timing lat2", 32'(cyc), 32'(e2.due));
          check("read data lat2", 32'(rd_data2), 32'(e2.data));
        end
      end else if (q2.size() > 0 && q2[0].due <= cyc) begin
        check("missing rd_valid lat2", 32'(rd_valid2), 32'd1);
        void'(q2.pop_front());
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Applies one cycle of stimulus; accepted reads register their expected results.
  task automatic drive(input vec_t vin, input bit push);
    wr_en   = vin.wr_en;
    wr_addr = vin.wr_addr;
    wr_data = vin.wr_data;
    rd_en   = vin.rd_en;
    rd_addr = vin.rd_addr;
    if (push && vin.rd_en) begin
      q1.push_back('{vin.exp1, cyc + 1});
      q2.push_back('{vin.exp2, cyc + 2});
    end
    step();
  endtask

  task automatic idle(input int n);
    wr_en = 1'b0;
    rd_en = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Keeps requesting during INIT (all must be ignored) and measures busy length.
  task automatic wait_init();
    int n;
    n = 0;
    while (busy1 && n < 1000) begin
      wr_en   = 1'b1;
      wr_addr = 8'h00;
      wr_data = 6'h3F;
      rd_en   = 1'b1;
      rd_addr = 8'h00;
      step();
      n++;
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("init_busy cycle count", 32'(n), 32'(DEPTH));
  endtask

  initial begin
    //          wr  waddr  wdata  rd  raddr  exp1   exp2
    tbl[0]  = '{1'b1, 8'h03, 6'h15, 1'b0, 8'h00, 6'h00, 6'h00};
    tbl[1]  = '{1'b0, 8'h00, 6'h00, 1'b1, 8'h03, 6'h15, 6'h15};
    tbl[2]  = '{1'b0, 8'h00, 6'h00, 1'b1, 8'h00, 6'h00, 6'h00};
    tbl[3]  = '{1'b1, 8'h40, 6'h01, 1'b0, 8'h00, 6'h00, 6'h00};
    tbl[4]  = '{1'b1, 8'h40, 6'h3F, 1'b1, 8'h40, 6'h3F, 6'h01};
    tbl[5]  = '{1'b0, 8'h00, 6'h00, 1'b1, 8'h40, 6'h3F, 6'h3F};
    tbl[6]  = '{1'b1, 8'h05, 6'h22, 1'b1, 8'h03, 6'h15, 6'h15};
    tbl[7]  = '{1'b0, 8'h00, 6'h00, 1'b1, 8'h05, 6'h22, 6'h22};
    tbl[8]  = '{1'b1, 8'hFF, 6'h2B, 1'b1, 8'hFF, 6'h2B, 6'h00};
    tbl[9]  = '{1'b0, 8'h00, 6'h00, 1'b1, 8'hFF, 6'h2B, 6'h2B};
    tbl[10] = '{1'b1, 8'h80, 6'h3C, 1'b1, 8'h7F, 6'h00, 6'h00};
    tbl[11] = '{1'b0, 8'h00, 6'h00, 1'b1, 8'h80, 6'h3C, 6'h3C};

    #1 reset = 1'b1;
    step();
    step();
    check("reset state rd_data lat1", 32'(rd_data1), 32'd0);
    check("reset state rd_data lat2", 32'(rd_data2), 32'd0);
    check("reset state init_busy", 32'(busy1), 32'd1);
    reset = 1'b0;
    wait_init();

    for (int i = 0; i < 12; i++) drive(tbl[i], 1'b1);
    idle(3);

    // Streaming: fill 0..7, then eight back-to-back reads.
    for (int i = 0; i < 8; i++) begin
      v = '{1'b1, AW'(i), DW'(i), 1'b0, 8'h00, 6'h00, 6'h00};
      drive(v, 1'b1);
    end
    for (int i = 0; i < 8; i++) begin
      v = '{1'b0, 8'h00, 6'h00, 1'b1, AW'(i), DW'(i), DW'(i)};
      drive(v, 1'b1);
    end
    idle(4);
    check("rd_data hold lat1", 32'(rd_data1), 32'h07);
    check("rd_data hold lat2", 32'(rd_data2), 32'h07);

    v = '{1'b1, 8'h10, 6'h2A, 1'b0, 8'h00, 6'h00, 6'h00};
    drive(v, 1'b1);
    v = '{1'b0, 8'h00, 6'h00, 1'b1, 8'h10, 6'h2A, 6'h2A};
    drive(v, 1'b1);
    idle(3);

    // Reset while the 2-cycle instance still has the read in flight.
    rd_en   = 1'b1;
    rd_addr = 8'h10;
    q1.push_back('{6'h2A, cyc + 1});
    step();
    rd_en = 1'b0;
    check("pre-reset rd_data lat1", 32'(rd_data1), 32'h2A);
    reset = 1'b1;
    q1.delete();
    q2.delete();
    #1;
    check("async reset rd_data lat1", 32'(rd_data1), 32'd0);
    check("async reset rd_valid lat1", 32'(rd_valid1), 32'd0);
    check("async reset rd_data lat2", 32'(rd_data2), 32'd0);
    check("async reset rd_valid lat2", 32'(rd_valid2), 32'd0);
    check("async reset init_busy", 32'(busy2), 32'd1);
    step();
    step();
    reset = 1'b0;
    wait_init();

    v = '{1'b0, 8'h00, 6'h00, 1'b1, 8'h10, 6'h00, 6'h00};
    drive(v, 1'b1);
    v = '{1'b0, 8'h00, 6'h00, 1'b1, 8'h00, 6'h00, 6'h00};
    drive(v, 1'b1);
    idle(5);

    check("scoreboard drained lat1", 32'(q1.size()), 32'd0);
    check("scoreboard drained lat2", 32'(q2.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
